// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: issues one sequential fetch per cycle to a
// one-cycle-latency instruction memory and presents results to decode.
// A one-entry skid buffer absorbs the response that is in flight when decode stalls.
//
// Handshake: an instruction on if_valid/if_pc/if_inst is consumed by decode on
// a rising edge where if_valid=1, stall_i=0 and redirect_i=0. A redirect
// discards everything presented, buffered or in flight. At most one fetch is
// ever outstanding.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        dbg_hold_o,
  output logic [31:0] dbg_skid_pc_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_v_q, inflight_v_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        issue;
  logic [31:0] issue_addr;
  logic        resp;

  always_comb begin
    issue      = redirect_i | ~stall_i;
    issue_addr = redirect_i ? (redirect_pc_i & WORD_MASK) : pc_q;
    resp       = inflight_v_q;
  end

  // Reset overrides the address so the memory sees RESET_PC before the first issue.
  always_comb begin
    if (!rst) begin
      imem_addr = RESET_PC & WORD_MASK;
    end else if (issue) begin
      imem_addr = issue_addr;
    end else begin
      imem_addr = pc_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_v_d  = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_v_d      = skid_v_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;

    if (issue) begin
      pc_d          = issue_addr + 32'd4;
      inflight_v_d  = 1'b1;
      inflight_pc_d = issue_addr;
    end

    if (redirect_i) begin
      if_valid_d = 1'b0;
      skid_v_d   = 1'b0;
      state_d    = RUN;
    end else if (!stall_i) begin
      // A full skid implies the previous cycle stalled, so nothing is arriving now.
      if (skid_v_q) begin
        if_valid_d = 1'b1;
        if_pc_d    = skid_pc_q;
        if_inst_d  = skid_inst_q;
        skid_v_d   = 1'b0;
      end else if (resp) begin
        if_valid_d = 1'b1;
        if_pc_d    = inflight_pc_q;
        if_inst_d  = imem_inst;
      end else begin
        if_valid_d = 1'b0;
      end
      state_d = RUN;
    end else if (resp) begin
      if (!if_valid_q) begin
        if_valid_d = 1'b1;
        if_pc_d    = inflight_pc_q;
        if_inst_d  = imem_inst;
      end else begin
        skid_v_d    = 1'b1;
        skid_pc_d   = inflight_pc_q;
        skid_inst_d = imem_inst;
        state_d     = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC & WORD_MASK;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= 32'd0;
      skid_v_q      <= 1'b0;
      skid_pc_q     <= 32'd0;
      skid_inst_q   <= 32'd0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_inst_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      skid_v_q      <= skid_v_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
    end
  end

  always_comb begin
    if_valid      = if_valid_q;
    if_pc         = if_pc_q;
    if_inst       = if_inst_q;
    dbg_hold_o    = (state_q == HOLD);
    dbg_skid_pc_o = skid_pc_q;
  end

endmodule
